// File: rtl/jtpinpon_objscan.sv
// rtl/jtpinpon_objscan.sv - per-line object table scanner feeding draw requests to the object drawer
// Fetches each 4-byte entry, tests vertical visibility against vdump and hands visible objects over.
module jtpinpon_objscan #(
  parameter int OBJCNT  = 32,
  parameter int LINEMAX = 8
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen2,
  input  logic       hinit_x,
  input  logic [7:0] vdump,
  output logic [7:0] obj_addr,
  input  logic [7:0] obj_dout,
  output logic       draw,
  input  logic       busy,
  output logic [7:0] xpos,
  output logic [3:0] ysub,
  output logic [4:0] pal,
  output logic       hflip,
  output logic       vflip,
  output logic [7:0] code,
  output logic       scan_busy
);
  localparam int EW = $clog2(OBJCNT);
  localparam int CW = $clog2(LINEMAX + 1);

  localparam logic [1:0] B_YPOS = 2'd0;
  localparam logic [1:0] B_CODE = 2'd1;
  localparam logic [1:0] B_ATTR = 2'd2;
  localparam logic [1:0] B_XPOS = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    REQ   = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        st;
  logic [EW-1:0] entry;
  logic [CW-1:0] count;
  logic [2:0]    fsub;
  logic [1:0]    lat_byte;
  logic          wait_first;
  logic [7:0]    ypos_l, code_l, xpos_l;
  logic [6:0]    attr_l;
  logic [7:0]    diff;
  logic          last;
  logic          unused_attr;

  // byte presented on fsub-1 is the one arriving on obj_dout now
  assign lat_byte    = fsub[1:0] - 2'd1;
  assign diff        = vdump - ypos_l;
  assign last        = (entry == EW'(OBJCNT - 1));
  assign unused_attr = obj_dout[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      draw       <= 1'b0;
      scan_busy  <= 1'b0;
      obj_addr   <= 8'd0;
      xpos       <= 8'd0;
      ysub       <= 4'd0;
      pal        <= 5'd0;
      hflip      <= 1'b0;
      vflip      <= 1'b0;
      code       <= 8'd0;
      entry      <= '0;
      count      <= '0;
      fsub       <= 3'd0;
      wait_first <= 1'b0;
      ypos_l     <= 8'd0;
      code_l     <= 8'd0;
      attr_l     <= 7'd0;
      xpos_l     <= 8'd0;
    end else if (cen2) begin
      if (hinit_x) begin
        st         <= FETCH;
        entry      <= '0;
        count      <= '0;
        fsub       <= 3'd0;
        draw       <= 1'b0;
        scan_busy  <= 1'b1;
        obj_addr   <= 8'd0;
        wait_first <= 1'b0;
      end else begin
        case (st)
          FETCH: begin
            if (fsub <= 3'd3) obj_addr <= {6'(entry), fsub[1:0]};
            if (fsub != 3'd0) begin
              case (lat_byte)
                B_YPOS:  ypos_l <= obj_dout;
                B_CODE:  code_l <= obj_dout;
                B_ATTR:  attr_l <= {obj_dout[7:6], obj_dout[4:0]};
                B_XPOS:  xpos_l <= obj_dout;
                default: ;
              endcase
            end
            if (fsub == 3'd4) begin
              fsub <= 3'd0;
              st   <= CHECK;
            end else begin
              fsub <= fsub + 3'd1;
            end
          end
          CHECK: begin
            if (diff < 8'd16) begin
              ysub  <= diff[3:0];
              xpos  <= xpos_l;
              code  <= code_l;
              pal   <= attr_l[4:0];
              hflip <= attr_l[5];
              vflip <= attr_l[6];
              st    <= REQ;
            end else if (last) begin
              st        <= DONE;
              scan_busy <= 1'b0;
            end else begin
              entry <= entry + 1'b1;
              st    <= FETCH;
            end
          end
          REQ: begin
            if (!busy) begin
              draw       <= 1'b1;
              count      <= count + 1'b1;
              wait_first <= 1'b1;
              st         <= WAIT;
            end else begin
              draw <= 1'b0;
            end
          end
          WAIT: begin
            draw <= 1'b0;
            // the drawer raises busy a cycle after draw, so the first cycle is blind
            if (wait_first) begin
              wait_first <= 1'b0;
            end else if (!busy) begin
              if (last || count == CW'(LINEMAX)) begin
                st        <= DONE;
                scan_busy <= 1'b0;
              end else begin
                entry <= entry + 1'b1;
                st    <= FETCH;
              end
            end
          end
          default: draw <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: doc/jtpinpon_objscan.md
JTPINPON_OBJSCAN -- requirements
Module: jtpinpon_objscan

Interface
REQ-001 SHALL have parameter OBJCNT, default 32, meaning the number of object table entries scanned per line (power of two, max 64).
REQ-002 SHALL have parameter LINEMAX, default 8, meaning the maximum number of draw requests issued per line.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port cen2  input  1  clock enable; all state advances only when cen2=1.
REQ-006 SHALL have port hinit_x  input  1  line-start pulse, one clk wide, which starts a new scan.
REQ-007 SHALL have port vdump  input  8  line to be drawn.
REQ-008 SHALL have port obj_addr  output  8  object RAM byte address, {entry, byte[1:0]}.
REQ-009 SHALL have port obj_dout  input  8  object RAM data, valid one cen2 cycle after obj_addr.
REQ-010 SHALL have port draw  output  1  draw request to the object drawer.
REQ-011 SHALL have port busy  input  1  drawer busy.
REQ-012 SHALL have ports xpos (output, 8), ysub (output, 4), pal (output, 5), hflip (output, 1), vflip (output, 1) and code (output, 8), which form the request payload.
REQ-013 SHALL have port scan_busy  output  1  high from scan start until the DONE state.

Function
REQ-014 SHALL use the entry byte layout: byte0 = ypos; byte1 = code; byte2 = {vflip, hflip, 1'b0, pal[4:0]}; byte3 = xpos.
REQ-015 SHALL implement the states IDLE, FETCH, CHECK, REQ, WAIT and DONE.
REQ-016 SHALL, in IDLE or DONE, move to FETCH on hinit_x, with entry=0 and count=0.
REQ-017 SHALL, in FETCH, present bytes 0..3 of the current entry on consecutive cen2 cycles and latch each byte one cen2 cycle later; the whole fetch SHALL take 5 cen2 cycles.
REQ-018 SHALL, in CHECK, compute diff = vdump - ypos modulo 256 (8-bit wrap).
REQ-019 SHALL treat the entry as visible iff diff < 16, and then set ysub = diff[3:0] and go to REQ.
REQ-020 SHALL, for a non-visible entry, advance to the next entry and return to FETCH.
REQ-021 SHALL, in REQ, hold the payload stable and assert draw for exactly one cen2 cycle, and only when busy=0; while busy=1 it SHALL stay in REQ with draw=0.
REQ-022 SHALL, in WAIT, ignore busy on the first cen2 cycle, then wait for busy=0; count SHALL increment on entry to WAIT.
REQ-023 SHALL hold the payload unchanged from draw assertion until WAIT exits.
REQ-024 SHALL go to DONE when the last entry (OBJCNT-1) is processed or when count reaches LINEMAX; no further requests SHALL be issued in that line.
REQ-025 SHALL hold DONE with draw=0 and scan_busy=0 until the next hinit_x.
REQ-026 SHALL treat hinit_x in any non-IDLE/DONE state as an abort: draw=0 immediately and the scan restarts in FETCH at entry 0; a request already accepted by the drawer is not tracked.
REQ-027 SHALL give hinit_x priority over every other transition when both occur on the same cycle.
REQ-028 SHALL register the draw and payload outputs; there is no combinational path from busy or obj_dout to any output.

Reset
REQ-029 SHALL, on rst, go to IDLE and set draw=0, scan_busy=0, obj_addr=0, xpos=0, ysub=0, pal=0, hflip=0, vflip=0, code=0, entry=0 and count=0.
REQ-030 SHALL make rst take effect mid-scan without waiting for busy.
REQ-031 SHALL, after rst is released, wait for hinit_x before the first scan.

Structure
REQ-032 SHALL be a single module with no sub-modules.
REQ-033 SHALL keep state encodings and byte offsets as local parameters; no shared package or include file.
REQ-034 SHALL size entry and count counters by $clog2 of OBJCNT and LINEMAX+1.

Verification
REQ-035 SHALL cover this scenario: vdump=0x40, entry 0 = {ypos=0x38, code=0x12, attr=0xC5, xpos=0x80}, other entries ypos=0xF0 -> exactly one draw, with ysub=8, pal=5, hflip=1, vflip=1, code=0x12, xpos=0x80.
REQ-036 SHALL cover wrap-around: vdump=0x03, ypos=0xFA -> draw with ysub=9; vdump=0x03, ypos=0xF3 (diff=16) -> no draw.
REQ-037 SHALL cover the line limit: all 32 entries visible, LINEMAX=8 -> exactly 8 draws (entries 0..7), then scan_busy=0.
REQ-038 SHALL cover the handshake: busy held high for 20 cen2 cycles after each draw -> the next draw appears only after busy falls, and the payload is stable throughout.
REQ-039 SHALL cover abort: hinit_x asserted while in WAIT at entry 5 -> draw stays 0 and the next obj_addr is 0x00.
REQ-040 SHALL cover reset: rst asserted while in REQ -> all outputs 0 on the same cycle, and no draw until a subsequent hinit_x.
